// File: rtl/srl_iter.sv
// rtl/srl_iter.sv - iterative 32-bit right shifter, one binary-weighted stage per clock
// Define SRL_ARITH_EN to honour the arith input (sign fill); otherwise the block is logical-only.
module srl_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data, data_nx;
    logic [SHW-1:0]   amt;
    logic [STW-1:0]   stage;
    logic             fill;
    logic             accept;
    logic             last_stage;

    assign accept     = (state == IDLE) && in_valid;
    assign last_stage = (stage == '0);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

`ifdef SRL_ARITH_EN
    // Fill is frozen from the original operand MSB, not re-derived per stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill <= 1'b0;
        end else if (accept) begin
            fill <= arith & in[WIDTH-1];
        end
    end
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign fill         = 1'b0;
`endif

    // The single reused stage: shift by 2^stage when that amount bit is set.
    always_comb begin
        data_nx = data;
        for (int s = 0; s < SHW; s++) begin
            if (stage == STW'(s) && amt[s]) begin
                data_nx = (data >> (1 << s)) | ({WIDTH{fill}} << (WIDTH - (1 << s)));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SHIFT;
            SHIFT:   if (last_stage) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            amt   <= '0;
            stage <= '0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in;
                        amt   <= shift;
                        stage <= STW'(SHW - 1);
                    end
                end
                SHIFT: begin
                    data <= data_nx;
                    if (last_stage) begin
                        out <= data_nx;
                    end else begin
                        stage <= stage - STW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_srl_iter.sv
// tb/tb_srl_iter.sv - directed and random checks for srl_iter
module tb_srl_iter;

`ifdef SRL_ARITH_EN
    localparam bit ARITH_ON = 1'b1;
`else
    localparam bit ARITH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din = '0;
    logic [4:0]  shift = '0;
    logic        arith = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    srl_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .shift     (shift),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a && ARITH_ON) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    // Present a request and return just after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic a);
        int n;
        n = 0;
        din = d;
        shift = s;
        arith = a;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] d, input logic [4:0] s,
                            input logic a, input logic [31:0] exp);
        send(d, s, a);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 4) check({tag, "_valid_lat"}, {31'b0, out_valid}, (k == 5) ? 32'd1 : 32'd0);
        end
        check(tag, dout, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ret_idle"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    logic [31:0] vec_in  [8];
    logic [4:0]  vec_sh  [8];
    logic        vec_ar  [8];
    logic [31:0] vec_exp [8];

    initial begin
        logic [31:0] d, exp, held;
        logic [4:0]  s;
        logic        a, seen;
        int          n, stall;

        vec_in[0] = 32'h80000000; vec_sh[0] = 5'd31; vec_ar[0] = 1'b0; vec_exp[0] = 32'h00000001;
        vec_in[1] = 32'h12345678; vec_sh[1] = 5'd0;  vec_ar[1] = 1'b0; vec_exp[1] = 32'h12345678;
        vec_in[2] = 32'h70000000; vec_sh[2] = 5'd4;  vec_ar[2] = 1'b1; vec_exp[2] = 32'h07000000;
        vec_in[3] = 32'hFFFFFFFF; vec_sh[3] = 5'd1;  vec_ar[3] = 1'b0; vec_exp[3] = 32'h7FFFFFFF;
        vec_in[4] = 32'hABCD1234; vec_sh[4] = 5'd16; vec_ar[4] = 1'b0; vec_exp[4] = 32'h0000ABCD;
        vec_in[5] = 32'h80000000; vec_sh[5] = 5'd31; vec_ar[5] = 1'b1;
        vec_in[6] = 32'hF0000000; vec_sh[6] = 5'd4;  vec_ar[6] = 1'b1;
        vec_in[7] = 32'hC0000001; vec_sh[7] = 5'd0;  vec_ar[7] = 1'b1; vec_exp[7] = 32'hC0000001;
`ifdef SRL_ARITH_EN
        vec_exp[5] = 32'hFFFFFFFF;
        vec_exp[6] = 32'hFF000000;
`else
        vec_exp[5] = 32'h00000001;
        vec_exp[6] = 32'h0F000000;
`endif

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out", dout, 32'h0);

        for (int i = 0; i < 8; i++) begin
            directed($sformatf("vec%0d", i), vec_in[i], vec_sh[i], vec_ar[i], vec_exp[i]);
        end

        // Backpressure: result held while a second request waits.
        send(32'hA5A50000, 5'd8, 1'b0);
        repeat (5) tick();
        check("bp_valid0", {31'b0, out_valid}, 32'd1);
        din = 32'h0000FF00;
        shift = 5'd4;
        arith = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out", dout, 32'h00A5A500);
            check("bp_hs", {30'b0, in_ready, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", {30'b0, in_ready, out_valid}, 32'd2);
        tick();
        check("bp_accept", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        repeat (5) tick();
        check("bp2_valid", {31'b0, out_valid}, 32'd1);
        check("bp2_out", dout, 32'h00000FF0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during SHIFT aborts and no result ever appears.
        send(32'hDEADBEEF, 5'd1, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_hs", {30'b0, in_ready, out_valid}, 32'd2);
        check("abort_out", dout, 32'h0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", {31'b0, seen}, 32'd0);
        check("abort_ready", {31'b0, in_ready}, 32'd1);

        // Random sweep, one outstanding op at a time, random consumer stalls.
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            exp = ref_shift(d, s, a);
            stall = $urandom_range(0, 3);
            send(d, s, a);
            if (stall == 0) out_ready = 1'b1;
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            check("rnd_latency", n, 5);
            check("rnd_out", dout, exp);
            held = dout;
            for (int k = 0; k < stall; k++) begin
                tick();
                check("rnd_stall", {dout[31:1], dout[0] ^ ~out_valid}, held);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("rnd_once", {30'b0, in_ready, out_valid}, 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
